lf_wide_add_seq: RTL and testbench

- Sequencer that feeds the 16-bit Ladner-Fischer prefix adder and consumes its result, one 16-bit slice per cycle.
- Builds WIDTH-bit add/subtract on top of the single combinational adder.
- Carry is chained between slices through a register.
- Sits between an operand producer and a result consumer, with valid/ready handshakes on both sides.

---
 rtl/lf_wide_add_seq.sv | 130 +++++++++++++
 tb/tb_lf_wide_add_seq.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/lf_wide_add_seq.sv
// Multi-pass WIDTH-bit add/subtract sequencer around an external 16-bit prefix adder.
// One 16-bit slice per RUN cycle, with the carry chained through a register between slices.
module lf_wide_add_seq #(
    parameter int WIDTH  = 64,
    parameter int NSLICE = WIDTH / 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf,
    output logic [15:0]      add_a,
    output logic [15:0]      add_b,
    output logic             add_cin,
    input  logic [15:0]      add_sum,
    input  logic             add_cout
);

    localparam int IW = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NSLICE - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_r;
    logic [IW-1:0]    idx_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic             first_r;
    logic             carry_r;
    logic [IW+3:0]    base_s;

    assign base_s = {idx_r, 4'b0000};

    // Handshake readiness depends only on state and consumer readiness.
    assign in_ready = (state_r == IDLE) || ((state_r == DONE) && out_ready);

    // Adder drive: current operand slice while running, quiet zeros otherwise.
    always_comb begin
        add_a   = 16'h0000;
        add_b   = 16'h0000;
        add_cin = 1'b0;
        case (state_r)
            RUN: begin
                add_a   = a_r[base_s +: 16];
                add_b   = b_r[base_s +: 16];
                add_cin = (idx_r == '0) ? first_r : carry_r;
            end
            default: begin
                add_a   = 16'h0000;
                add_b   = 16'h0000;
                add_cin = 1'b0;
            end
        endcase
    end

    // Sequencer state, operand latches, carry chain and registered results.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            idx_r     <= '0;
            a_r       <= '0;
            b_r       <= '0;
            first_r   <= 1'b0;
            carry_r   <= 1'b0;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_cout  <= 1'b0;
            out_ovf   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        a_r     <= in_a;
                        b_r     <= in_sub ? ~in_b : in_b;
                        first_r <= in_sub | in_cin;
                        idx_r   <= '0;
                        state_r <= RUN;
                    end
                end
                RUN: begin
                    out_sum[base_s +: 16] <= add_sum;
                    carry_r               <= add_cout;
                    if (idx_r == LAST_IDX) begin
                        idx_r     <= '0;
                        state_r   <= DONE;
                        out_valid <= 1'b1;
                        out_cout  <= add_cout;
                        // Signed overflow: like-signed operands yielding a result of the other sign.
                        out_ovf   <= (a_r[WIDTH-1] == b_r[WIDTH-1]) &&
                                     (add_sum[15] != a_r[WIDTH-1]);
                    end else begin
                        idx_r <= idx_r + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (in_valid) begin
                            a_r     <= in_a;
                            b_r     <= in_sub ? ~in_b : in_b;
                            first_r <= in_sub | in_cin;
                            idx_r   <= '0;
                            state_r <= RUN;
                        end else begin
                            state_r <= IDLE;
                        end
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    idx_r     <= '0;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lf_wide_add_seq.sv
// Directed bench for lf_wide_add_seq (WIDTH=64) with a behavioural 16-bit adder attached.
module tb_lf_wide_add_seq;

    localparam int WIDTH  = 64;
    localparam int NSLICE = WIDTH / 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_cin;
    logic             in_sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;
    logic             out_ovf;
    logic [15:0]      add_a;
    logic [15:0]      add_b;
    logic             add_cin;
    logic [15:0]      add_sum;
    logic             add_cout;

    int n_vec = 0;
    int n_err = 0;
    logic cin_seen [0:31];
    logic [15:0] a_seen [0:31];

    lf_wide_add_seq #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_sub(in_sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_cout(out_cout), .out_ovf(out_ovf),
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
        .add_sum(add_sum), .add_cout(add_cout)
    );

    // Stand-in for the combinational prefix adder.
    assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {16'h0000, add_cin};

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic start_op(input logic [63:0] a, input logic [63:0] b,
                            input logic cin, input logic sub);
        int n;
        n = 0;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        check("ready_before_accept", in_ready, 1'b1);
        in_valid = 1'b1;
        in_a = a; in_b = b; in_cin = cin; in_sub = sub;
        tick();
        in_valid = 1'b0;
        // Operands change after accept; the result must not follow them.
        in_a = {$urandom, $urandom}; in_b = {$urandom, $urandom};
        in_cin = ~cin; in_sub = ~sub;
    endtask

    task automatic wait_done(output int cycles);
        cycles = 0;
        while (!out_valid && cycles < 20) begin
            cin_seen[cycles] = add_cin;
            a_seen[cycles]   = add_a;
            tick();
            cycles++;
        end
    endtask

    task automatic finish_op(input string tag, input logic [63:0] exp_sum,
                             input logic exp_cout, input logic exp_ovf);
        int cyc;
        wait_done(cyc);
        check({tag, "_latency"}, 64'(cyc), 64'(NSLICE));
        check({tag, "_sum"}, out_sum, exp_sum);
        check({tag, "_cout"}, out_cout, exp_cout);
        check({tag, "_ovf"}, out_ovf, exp_ovf);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_valid_drop"}, out_valid, 1'b0);
    endtask

    initial begin
        logic [63:0] held_sum;
        logic        held_cout;
        logic        held_ovf;
        int          cyc;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        in_a = '0; in_b = '0; in_cin = 1'b0; in_sub = 1'b0;
        tick(); tick();
        rst = 1'b0;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_sum", out_sum, 64'h0);
        check("rst_out_cout", out_cout, 1'b0);
        check("rst_out_ovf", out_ovf, 1'b0);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_add_a", add_a, 16'h0000);

        // All-ones plus one wraps to zero with carry-out.
        start_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0);
        finish_op("t1", 64'h0, 1'b1, 1'b0);
        check("idle_add_a", add_a, 16'h0000);
        check("idle_add_cin", add_cin, 1'b0);

        // Carry crossing slice 0 into slice 1.
        start_op(64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 1'b0);
        finish_op("t2", 64'h0000_0000_0001_0000, 1'b0, 1'b0);
        check("t2_cin_idx0", cin_seen[0], 1'b0);
        check("t2_cin_idx1", cin_seen[1], 1'b1);
        check("t2_cin_idx2", cin_seen[2], 1'b0);

        // Subtraction with and without borrow; cin ignored.
        start_op(64'd5, 64'd7, 1'b0, 1'b1);
        finish_op("t3a", 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);
        check("t3a_first_cin", cin_seen[0], 1'b1);
        start_op(64'd7, 64'd5, 1'b0, 1'b1);
        finish_op("t3b", 64'd2, 1'b1, 1'b0);

        // Positive and negative signed overflow.
        start_op(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0);
        finish_op("t4", 64'h8000_0000_0000_0000, 1'b0, 1'b1);
        start_op(64'h8000_0000_0000_0000, 64'h1, 1'b1, 1'b1);
        finish_op("t4neg", 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);

        // Add with carry-in, and per-slice operand drive.
        start_op(64'h0004_0003_0002_1234, 64'h0000_0000_0000_0001, 1'b1, 1'b0);
        finish_op("t_cin", 64'h0004_0003_0002_1236, 1'b0, 1'b0);
        check("t_cin_slice2_a", a_seen[2], 16'h0003);

        // Backpressure in DONE, then back-to-back accept.
        start_op(64'h1111_2222_3333_4444, 64'h0101_0101_0101_0101, 1'b0, 1'b0);
        wait_done(cyc);
        check("t5_latency", 64'(cyc), 64'(NSLICE));
        held_sum = out_sum; held_cout = out_cout; held_ovf = out_ovf;
        check("t5_sum", held_sum, 64'h1212_2323_3434_4545);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t5_hold_valid", out_valid, 1'b1);
            check("t5_hold_sum", out_sum, 64'h1212_2323_3434_4545);
            check("t5_hold_cout", out_cout, held_cout);
            check("t5_hold_ovf", out_ovf, held_ovf);
            check("t5_hold_in_ready", in_ready, 1'b0);
        end
        out_ready = 1'b1;
        in_valid = 1'b1; in_a = 64'h10; in_b = 64'h20; in_cin = 1'b0; in_sub = 1'b0;
        #1;
        check("t5_in_ready_b2b", in_ready, 1'b1);
        tick();
        out_ready = 1'b0; in_valid = 1'b0;
        check("t5_b2b_valid", out_valid, 1'b0);
        check("t5_b2b_run_ready", in_ready, 1'b0);
        check("t5_b2b_run_add_a", add_a, 16'h0010);
        finish_op("t5b", 64'h30, 1'b0, 1'b0);

        // Reset in the middle of RUN discards the operation.
        start_op(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0);
        tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t6_valid", out_valid, 1'b0);
        check("t6_sum", out_sum, 64'h0);
        check("t6_in_ready", in_ready, 1'b1);
        check("t6_add_cin", add_cin, 1'b0);
        start_op(64'd3, 64'd4, 1'b0, 1'b0);
        finish_op("t6_after", 64'd7, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
